// File: rtl/lsu_dccm_mem_pkg.sv
// rtl/lsu_dccm_mem_pkg.sv - shared DCCM geometry, word type and address decode helpers
package lsu_dccm_mem_pkg;

    localparam int DCCM_BITS        = 16;
    localparam int DCCM_FDATA_WIDTH = 39;
    localparam int DCCM_NUM_BANKS   = 8;
    localparam int DCCM_BYTE_WIDTH  = 4;
    localparam int BANK_BITS        = $clog2(DCCM_NUM_BANKS);
    localparam int WB               = $clog2(DCCM_BYTE_WIDTH);
    localparam int INDEX_BITS       = DCCM_BITS - WB - BANK_BITS;

    typedef logic [DCCM_FDATA_WIDTH-1:0] dccm_fdata_t;
    typedef logic [BANK_BITS-1:0]        dccm_bank_t;
    typedef logic [INDEX_BITS-1:0]       dccm_index_t;

    // Banks interleave on word address, so the bank sits just above the byte offset.
    function automatic dccm_bank_t dccm_bank_f(input logic [DCCM_BITS-1:0] addr);
        return addr[WB +: BANK_BITS];
    endfunction

    function automatic dccm_index_t dccm_index_f(input logic [DCCM_BITS-1:0] addr);
        return addr[DCCM_BITS-1 : WB+BANK_BITS];
    endfunction

endpackage

// File: rtl/lsu_dccm_bank.sv
// rtl/lsu_dccm_bank.sv - one single-port DCCM bank with a held, registered read port
module lsu_dccm_bank
    import lsu_dccm_mem_pkg::*;
#(
    parameter int IDX_W  = INDEX_BITS,
    parameter int DATA_W = DCCM_FDATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              en,
    input  logic              wr,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // The array itself is never reset; its contents survive rst_l.
    always_ff @(posedge clk) begin
        if (en && wr) begin
            mem[index] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rdata <= '0;
        end else if (en && !wr) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/lsu_dccm_mem.sv
// rtl/lsu_dccm_mem.sv - banked DCCM responder: decode, dc2 read muxes, collision reporting
module lsu_dccm_mem #(
    parameter int DCCM_BITS        = lsu_dccm_mem_pkg::DCCM_BITS,
    parameter int DCCM_FDATA_WIDTH = lsu_dccm_mem_pkg::DCCM_FDATA_WIDTH,
    parameter int DCCM_NUM_BANKS   = lsu_dccm_mem_pkg::DCCM_NUM_BANKS,
    parameter int DCCM_BYTE_WIDTH  = lsu_dccm_mem_pkg::DCCM_BYTE_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        dccm_wren,
    input  logic                        dccm_rden,
    input  logic [DCCM_BITS-1:0]        dccm_wr_addr,
    input  logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
    input  logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi,
    output logic                        dccm_bank_conflict,
    output logic [7:0]                  dccm_conflict_cnt,
    input  logic                        dccm_conflict_clr
);

    import lsu_dccm_mem_pkg::*;

    localparam int BANK_BITS  = $clog2(DCCM_NUM_BANKS);
    localparam int WB         = $clog2(DCCM_BYTE_WIDTH);
    localparam int INDEX_BITS = DCCM_BITS - WB - BANK_BITS;

    logic [BANK_BITS-1:0]        bank_lo, bank_hi, bank_wr;
    logic [BANK_BITS-1:0]        bank_lo_q, bank_hi_q;
    logic [INDEX_BITS-1:0]       index_lo, index_hi, index_wr;
    logic [DCCM_NUM_BANKS-1:0]   rd, wr, bank_en, bank_we, conflict;
    logic [INDEX_BITS-1:0]       bank_index [DCCM_NUM_BANKS];
    logic [DCCM_FDATA_WIDTH-1:0] bank_rdata [DCCM_NUM_BANKS];

    assign bank_lo  = dccm_bank_f(dccm_rd_addr_lo);
    assign bank_hi  = dccm_bank_f(dccm_rd_addr_hi);
    assign bank_wr  = dccm_bank_f(dccm_wr_addr);
    assign index_lo = dccm_index_f(dccm_rd_addr_lo);
    assign index_hi = dccm_index_f(dccm_rd_addr_hi);
    assign index_wr = dccm_index_f(dccm_wr_addr);

    // Each bank carries its own index, so a lo/hi pair wrapping from the last bank to bank 0 decodes naturally.
    always_comb begin
        rd         = '0;
        wr         = '0;
        bank_index = '{default: '0};
        for (int b = 0; b < DCCM_NUM_BANKS; b++) begin
            rd[b] = dccm_rden && ((bank_lo == BANK_BITS'(b)) || (bank_hi == BANK_BITS'(b)));
            wr[b] = dccm_wren && (bank_wr == BANK_BITS'(b));
            if (rd[b]) begin
                bank_index[b] = (bank_lo == BANK_BITS'(b)) ? index_lo : index_hi;
            end else begin
                bank_index[b] = index_wr;
            end
        end
    end

    // On a collision the read keeps the bank and the write is dropped.
    assign conflict = rd & wr;
    assign bank_en  = rd | wr;
    assign bank_we  = wr & ~rd;

    for (genvar g = 0; g < DCCM_NUM_BANKS; g++) begin : g_bank
        lsu_dccm_bank #(
            .IDX_W  (INDEX_BITS),
            .DATA_W (DCCM_FDATA_WIDTH)
        ) u_bank (
            .clk   (clk),
            .rst_l (rst_l),
            .en    (bank_en[g]),
            .wr    (bank_we[g]),
            .index (bank_index[g]),
            .wdata (dccm_wr_data),
            .rdata (bank_rdata[g])
        );
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            bank_lo_q <= '0;
            bank_hi_q <= '0;
        end else if (dccm_rden) begin
            bank_lo_q <= bank_lo;
            bank_hi_q <= bank_hi;
        end
    end

    assign dccm_rd_data_lo = bank_rdata[bank_lo_q];
    assign dccm_rd_data_hi = bank_rdata[bank_hi_q];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            dccm_bank_conflict <= 1'b0;
            dccm_conflict_cnt  <= '0;
        end else if (dccm_conflict_clr) begin
            dccm_bank_conflict <= 1'b0;
            dccm_conflict_cnt  <= '0;
        end else if (|conflict) begin
            dccm_bank_conflict <= 1'b1;
            if (dccm_conflict_cnt != 8'hFF) begin
                dccm_conflict_cnt <= dccm_conflict_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_dccm_mem.sv
// tb/tb_lsu_dccm_mem.sv - randomized and directed bench for lsu_dccm_mem against a word-level model
module tb_lsu_dccm_mem;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        dccm_wren = 1'b0, dccm_rden = 1'b0, dccm_conflict_clr = 1'b0;
    logic [15:0] dccm_wr_addr = '0, dccm_rd_addr_lo = '0, dccm_rd_addr_hi = '0;
    logic [38:0] dccm_wr_data = '0;
    logic [38:0] dccm_rd_data_lo, dccm_rd_data_hi;
    logic        dccm_bank_conflict;
    logic [7:0]  dccm_conflict_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [38:0] mem_m [int];
    logic [38:0] exp_lo = '0, exp_hi = '0;
    logic        exp_flag = 1'b0;
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    lsu_dccm_mem dut (
        .clk                (clk),
        .rst_l              (rst_l),
        .dccm_wren          (dccm_wren),
        .dccm_rden          (dccm_rden),
        .dccm_wr_addr       (dccm_wr_addr),
        .dccm_rd_addr_lo    (dccm_rd_addr_lo),
        .dccm_rd_addr_hi    (dccm_rd_addr_hi),
        .dccm_wr_data       (dccm_wr_data),
        .dccm_rd_data_lo    (dccm_rd_data_lo),
        .dccm_rd_data_hi    (dccm_rd_data_hi),
        .dccm_bank_conflict (dccm_bank_conflict),
        .dccm_conflict_cnt  (dccm_conflict_cnt),
        .dccm_conflict_clr  (dccm_conflict_clr)
    );

    function automatic int word_of(input logic [15:0] a);
        return int'(a) / 4;
    endfunction

    function automatic int bank_of(input logic [15:0] a);
        return (int'(a) / 4) % 8;
    endfunction

    // Drive one cycle of requests and advance the word-level model across the edge.
    task automatic tick(input logic wr, input logic rd, input logic [15:0] wa, input logic [15:0] lo,
                        input logic [15:0] hi, input logic [38:0] wd, input logic clr);
        bit collide;
        dccm_wren = wr; dccm_rden = rd; dccm_wr_addr = wa; dccm_rd_addr_lo = lo;
        dccm_rd_addr_hi = hi; dccm_wr_data = wd; dccm_conflict_clr = clr;
        collide = rd && wr && (bank_of(wa) == bank_of(lo) || bank_of(wa) == bank_of(hi));
        @(posedge clk);
        #1;
        if (clr) begin
            exp_flag = 1'b0; exp_cnt = 0;
        end else if (collide) begin
            exp_flag = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
        end
        if (rd) begin
            exp_lo = mem_m[word_of(lo)];
            exp_hi = mem_m[word_of(hi)];
        end
        if (wr && !collide) mem_m[word_of(wa)] = wd;
        @(negedge clk);
        dccm_wren = 1'b0; dccm_rden = 1'b0; dccm_conflict_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (2) @(negedge clk);
        vectors += 4;
        if (dccm_rd_data_lo !== 39'h0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", dccm_rd_data_lo); end
        if (dccm_rd_data_hi !== 39'h0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", dccm_rd_data_hi); end
        if (dccm_bank_conflict !== 1'b0) begin miscompares++; $display("FAIL reset_flag: got %b want 0", dccm_bank_conflict); end
        if (dccm_conflict_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", dccm_conflict_cnt); end
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        tick(1, 0, 16'h0010, 16'h0, 16'h0, 39'h7F_DEADBEEF, 0);
        tick(0, 1, 16'h0, 16'h0010, 16'h0010, 39'h0, 0);
        vectors += 2;
        if (dccm_rd_data_lo !== 39'h7F_DEADBEEF) begin miscompares++; $display("FAIL basic_lo: got %h want 7fdeadbeef", dccm_rd_data_lo); end
        if (dccm_rd_data_hi !== 39'h7F_DEADBEEF) begin miscompares++; $display("FAIL basic_hi: got %h want 7fdeadbeef", dccm_rd_data_hi); end
        tick(0, 0, 16'h0, 16'h0, 16'h0, 39'h0, 0);
        vectors += 2;
        if (dccm_rd_data_lo !== 39'h7F_DEADBEEF) begin miscompares++; $display("FAIL hold_lo: got %h want 7fdeadbeef", dccm_rd_data_lo); end
        if (dccm_rd_data_hi !== 39'h7F_DEADBEEF) begin miscompares++; $display("FAIL hold_hi: got %h want 7fdeadbeef", dccm_rd_data_hi); end
    endtask

    task automatic test_wrap();
        tick(1, 0, 16'h001C, 16'h0, 16'h0, 39'h11, 0);
        tick(1, 0, 16'h0020, 16'h0, 16'h0, 39'h22, 0);
        tick(0, 1, 16'h0, 16'h001E, 16'h0021, 39'h0, 0);
        vectors += 2;
        if (dccm_rd_data_lo !== 39'h11) begin miscompares++; $display("FAIL wrap_lo: got %h want 11", dccm_rd_data_lo); end
        if (dccm_rd_data_hi !== 39'h22) begin miscompares++; $display("FAIL wrap_hi: got %h want 22", dccm_rd_data_hi); end
    endtask

    task automatic test_parallel();
        tick(1, 0, 16'h0040, 16'h0, 16'h0, 39'h33, 0);
        tick(1, 1, 16'h0044, 16'h0040, 16'h0040, 39'h44AB, 0);
        vectors += 3;
        if (dccm_rd_data_lo !== 39'h33) begin miscompares++; $display("FAIL par_lo: got %h want 33", dccm_rd_data_lo); end
        if (dccm_rd_data_hi !== 39'h33) begin miscompares++; $display("FAIL par_hi: got %h want 33", dccm_rd_data_hi); end
        if (dccm_bank_conflict !== 1'b0) begin miscompares++; $display("FAIL par_flag: got %b want 0", dccm_bank_conflict); end
        tick(0, 1, 16'h0, 16'h0044, 16'h0044, 39'h0, 0);
        vectors++;
        if (dccm_rd_data_lo !== 39'h44AB) begin miscompares++; $display("FAIL par_write: got %h want 44ab", dccm_rd_data_lo); end
    endtask

    task automatic test_conflict();
        tick(1, 0, 16'h0060, 16'h0, 16'h0, 39'h66, 0);
        tick(0, 0, 16'h0, 16'h0, 16'h0, 39'h0, 1);
        tick(1, 1, 16'h0060, 16'h0040, 16'h0040, 39'h55, 0);
        vectors += 3;
        if (dccm_rd_data_lo !== 39'h33) begin miscompares++; $display("FAIL col_read: got %h want 33", dccm_rd_data_lo); end
        if (dccm_bank_conflict !== 1'b1) begin miscompares++; $display("FAIL col_flag: got %b want 1", dccm_bank_conflict); end
        if (dccm_conflict_cnt !== 8'd1) begin miscompares++; $display("FAIL col_cnt: got %0d want 1", dccm_conflict_cnt); end
        tick(0, 1, 16'h0, 16'h0060, 16'h0060, 39'h0, 0);
        vectors += 2;
        if (dccm_rd_data_lo !== 39'h66) begin miscompares++; $display("FAIL col_dropped: got %h want 66", dccm_rd_data_lo); end
        if (dccm_bank_conflict !== 1'b1) begin miscompares++; $display("FAIL col_sticky: got %b want 1", dccm_bank_conflict); end
        for (int i = 0; i < 299; i++) begin
            tick(1, 1, 16'h0060, 16'h0040, 16'h0040, 39'(i), 0);
            vectors++;
            if (dccm_conflict_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL col_count[%0d]: got %0d want %0d", i, dccm_conflict_cnt, exp_cnt); end
        end
        vectors++;
        if (dccm_conflict_cnt !== 8'd255) begin miscompares++; $display("FAIL col_saturate: got %0d want 255", dccm_conflict_cnt); end
        tick(0, 0, 16'h0, 16'h0, 16'h0, 39'h0, 1);
        vectors += 2;
        if (dccm_bank_conflict !== 1'b0) begin miscompares++; $display("FAIL clr_flag: got %b want 0", dccm_bank_conflict); end
        if (dccm_conflict_cnt !== 8'd0) begin miscompares++; $display("FAIL clr_cnt: got %0d want 0", dccm_conflict_cnt); end
        tick(1, 1, 16'h0060, 16'h0040, 16'h0040, 39'h77, 1);
        vectors += 2;
        if (dccm_bank_conflict !== 1'b0) begin miscompares++; $display("FAIL clr_wins_flag: got %b want 0", dccm_bank_conflict); end
        if (dccm_conflict_cnt !== 8'd0) begin miscompares++; $display("FAIL clr_wins_cnt: got %0d want 0", dccm_conflict_cnt); end
        tick(1, 1, 16'h0060, 16'h0040, 16'h0040, 39'h78, 0);
        vectors++;
        if (dccm_conflict_cnt !== 8'd1) begin miscompares++; $display("FAIL clr_then_col: got %0d want 1", dccm_conflict_cnt); end
        tick(0, 1, 16'h0, 16'h0060, 16'h0060, 39'h0, 0);
        vectors++;
        if (dccm_rd_data_lo !== 39'h66) begin miscompares++; $display("FAIL col_unchanged: got %h want 66", dccm_rd_data_lo); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        for (int k = 0; k < 3; k++) begin
            r = {$urandom(), $urandom()};
            tick(1, 0, 16'h0100, 16'h0, 16'h0, r[38:0], 0);
            tick(0, 1, 16'h0, 16'h0100, 16'h0100, 39'h0, 0);
            vectors++;
            if (dccm_rd_data_lo !== r[38:0]) begin miscompares++; $display("FAIL b2b[%0d]: got %h want %h", k, dccm_rd_data_lo, r[38:0]); end
        end
    endtask

    task automatic test_random();
        logic [63:0] r;
        logic [15:0] lo, hi, wa;
        int          w;
        for (int i = 0; i < 64; i++) begin
            r = {$urandom(), $urandom()};
            tick(1, 0, 16'(i * 4), 16'h0, 16'h0, r[38:0], 0);
        end
        for (int i = 0; i < 400; i++) begin
            r  = {$urandom(), $urandom()};
            w  = int'($urandom_range(0, 62));
            lo = 16'(w * 4 + int'($urandom_range(0, 3)));
            hi = 16'((w + int'($urandom_range(0, 1))) * 4 + int'($urandom_range(0, 3)));
            wa = 16'(int'($urandom_range(0, 63)) * 4 + int'($urandom_range(0, 3)));
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, wa, lo, hi, r[38:0], $urandom_range(0, 15) == 0);
            vectors += 4;
            if (dccm_rd_data_lo !== exp_lo) begin miscompares++; $display("FAIL rand_lo[%0d]: got %h want %h", i, dccm_rd_data_lo, exp_lo); end
            if (dccm_rd_data_hi !== exp_hi) begin miscompares++; $display("FAIL rand_hi[%0d]: got %h want %h", i, dccm_rd_data_hi, exp_hi); end
            if (dccm_bank_conflict !== exp_flag) begin miscompares++; $display("FAIL rand_flag[%0d]: got %b want %b", i, dccm_bank_conflict, exp_flag); end
            if (dccm_conflict_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, dccm_conflict_cnt, exp_cnt); end
        end
    endtask

    task automatic test_async_reset();
        tick(1, 0, 16'h0200, 16'h0, 16'h0, 39'h5A_5A5A5A5A, 0);
        tick(1, 1, 16'h0060, 16'h0040, 16'h0040, 39'h1, 0);
        tick(0, 1, 16'h0, 16'h0200, 16'h0200, 39'h0, 0);
        vectors += 2;
        if (dccm_rd_data_lo !== 39'h5A_5A5A5A5A) begin miscompares++; $display("FAIL pre_rst_lo: got %h want 5a5a5a5a5a", dccm_rd_data_lo); end
        if (dccm_bank_conflict !== 1'b1) begin miscompares++; $display("FAIL pre_rst_flag: got %b want 1", dccm_bank_conflict); end
        dccm_rden = 1'b1; dccm_rd_addr_lo = 16'h0200; dccm_rd_addr_hi = 16'h0200;
        #2 rst_l = 1'b0;
        #1;
        vectors += 4;
        if (dccm_rd_data_lo !== 39'h0) begin miscompares++; $display("FAIL async_lo: got %h want 0", dccm_rd_data_lo); end
        if (dccm_rd_data_hi !== 39'h0) begin miscompares++; $display("FAIL async_hi: got %h want 0", dccm_rd_data_hi); end
        if (dccm_bank_conflict !== 1'b0) begin miscompares++; $display("FAIL async_flag: got %b want 0", dccm_bank_conflict); end
        if (dccm_conflict_cnt !== 8'd0) begin miscompares++; $display("FAIL async_cnt: got %0d want 0", dccm_conflict_cnt); end
        @(negedge clk);
        dccm_rden = 1'b0;
        rst_l = 1'b1;
        exp_lo = '0; exp_hi = '0; exp_flag = 1'b0; exp_cnt = 0;
        tick(0, 0, 16'h0, 16'h0, 16'h0, 39'h0, 0);
        vectors += 2;
        if (dccm_rd_data_lo !== 39'h0) begin miscompares++; $display("FAIL inflight_lo: got %h want 0", dccm_rd_data_lo); end
        if (dccm_rd_data_hi !== 39'h0) begin miscompares++; $display("FAIL inflight_hi: got %h want 0", dccm_rd_data_hi); end
        tick(0, 1, 16'h0, 16'h0200, 16'h0200, 39'h0, 0);
        vectors++;
        if (dccm_rd_data_lo !== 39'h5A_5A5A5A5A) begin miscompares++; $display("FAIL post_rst_data: got %h want 5a5a5a5a5a", dccm_rd_data_lo); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_parallel();
        test_conflict();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
